uart_receiver: RTL and testbench
================================

# uart_receiver

UART receive path that pairs with the team's UART transmitter over one serial line. It oversamples the asynchronous RX line using the shared baud-rate tick, detects and qualifies the start bit, and samples each data bit at mid-bit. It assembles an LSB-first word, optionally checks a parity bit, verifies the stop bit, and presents the word with a one-cycle done strobe plus error flags to the controller side.

## Interface
Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- OVERSAMPLE, 16, baud ticks per bit period; must be even and at least 4.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- RX_BR_TICKS  input  1  single-cycle baud tick at OVERSAMPLE × baud rate.
- PARITY_EN  input  1  1 = frame carries a parity bit after the data.
- PARITY_MODE  input  1  0 = even parity, 1 = odd parity.
- RX  input  1  asynchronous serial line; idles high.
- RX_DATA_OUT  output  DATA_WIDTH  last received word.
- RX_DONE  output  1  one-cycle pulse when a frame completes.
- PARITY_ERR  output  1  parity mismatch on the last frame.
- FRAME_ERR  output  1  stop bit sampled low on the last frame.
- State_dbg  output  3  current FSM state, for bench visibility.

## Operation
- RX passes through a 2-flop synchronizer whose flops reset to 1. All FSM logic uses the synchronized value, called rx_s.
- The tick counter is $clog2(OVERSAMPLE) bits wide and advances only on cycles where RX_BR_TICKS=1.
- The state encoding is IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- IDLE:
  - rx_s=0 → clear the tick counter, latch PARITY_EN and PARITY_MODE for this frame, go to START.
  - Changes to PARITY_EN or PARITY_MODE during a frame are ignored.
- START: on the tick where count = OVERSAMPLE/2−1 (mid start bit):
  - If rx_s=0: clear the count and bit index, go to DATA.
  - If rx_s=1: treat it as a glitch and return to IDLE with no strobe and no flag change.
- DATA:
  - On the tick where count = OVERSAMPLE−1, shift rx_s into the MSB of the shift register (shift right) and clear the count.
  - After bit DATA_WIDTH−1, go to PARITY if the latched enable is set, otherwise go to STOP.
- PARITY: on the mid-bit tick, capture rx_s as the received parity bit, then go to STOP.
- STOP: on the mid-bit tick, sample the stop bit and then, in the next cycle:
  - RX_DATA_OUT ← shift register.
  - FRAME_ERR ← ~stop sample.
  - PARITY_ERR ← (expected ≠ received) when parity is enabled, else 0.
  - RX_DONE = 1.
  - Return to IDLE.
- Expected parity is the XOR of the data bits, XOR PARITY_MODE.
- A frame with FRAME_ERR or PARITY_ERR still delivers its data and pulses RX_DONE.
- The receiver returns to IDLE at mid-stop-bit. A start edge arriving half a bit later is therefore caught; back-to-back frames with one stop bit are supported.
- Illegal state codes go to IDLE on the next clock.

## Timing
- Reset values: RX_DATA_OUT=0, RX_DONE=0, PARITY_ERR=0, FRAME_ERR=0, State_dbg=IDLE, synchronizer=1s.
- Reset asserted mid-frame aborts immediately. After release the block waits in IDLE for the next falling edge, with no strobe.
- RX-to-FSM latency is 2 CLK cycles through the synchronizer.
- RX_DONE is high for exactly one CLK cycle, one cycle after the stop-bit mid-tick.
- RX_DATA_OUT and both error flags change only in the RX_DONE cycle and hold until the next RX_DONE.
- A start glitch must hold for OVERSAMPLE/2 ticks to be accepted. Shorter lows produce no output.
- The counter must never wrap inside a state: comparisons are equality on the terminal count, with a clear on transition.
- There is no handshake back-pressure. A consumer that misses RX_DONE loses only the strobe, not the data, until the next frame.

## Structure
- The shared UART package holds:
  - the state localparams (IDLE..STOP), common with the transmitter;
  - the parity-mode encoding constants (EVEN=0, ODD=1);
  - the default OVERSAMPLE=16.
- Sub-module: instantiate the existing PARITY_CHECKER on the assembled word to compute expected parity. Do not re-implement the XOR tree.
- Everything else lives in one module: synchronizer, FSM, counters, shift register, and output registers.

## Test plan
- Valid frame, no parity: PARITY_EN=0, drive 0xA5 at 16 ticks/bit → RX_DATA_OUT=0xA5, one RX_DONE pulse, PARITY_ERR=0, FRAME_ERR=0.
- Correct even parity: PARITY_EN=1, PARITY_MODE=0, data 0x3C with parity bit 0 → 0x3C, no errors.
- Wrong parity: same settings, data 0x3C with parity bit 1 → 0x3C, PARITY_ERR=1, RX_DONE pulsed.
- Framing error: data 0x81 with stop bit driven 0 → FRAME_ERR=1, RX_DATA_OUT=0x81.
- Start glitch: RX low for 5 ticks then high → FSM returns to IDLE, no RX_DONE, outputs unchanged.
- Reset and back-to-back frames:
  - Assert RESET_N low during DATA bit 3 → all outputs at reset values.
  - Then send 0x55 immediately followed by 0xF0 → two RX_DONE pulses with the correct words.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared UART state encoding, parity modes and defaults
package uart_receiver_pkg;

  // State codes are shared with the transmitter and exposed on State_dbg.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_receiver_parity_checker.sv
// rtl/uart_receiver_parity_checker.sv - expected parity bit for a data word
module parity_checker
  import uart_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  mode_i,
  output logic                  parity_o
);

  assign parity_o = (^data_i) ^ (mode_i == PARITY_ODD);

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampled UART receiver with parity and framing checks
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  RX_BR_TICKS,
  input  logic                  PARITY_EN,
  input  logic                  PARITY_MODE,
  input  logic                  RX,
  output logic [DATA_WIDTH-1:0] RX_DATA_OUT,
  output logic                  RX_DONE,
  output logic                  PARITY_ERR,
  output logic                  FRAME_ERR,
  output logic [2:0]            State_dbg
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_CNT  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d, par_mode_q, par_mode_d;
  logic                  par_bit_q, par_bit_d;
  logic                  done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  exp_parity;

  parity_checker #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data_i   (shift_q),
    .mode_i   (par_mode_q),
    .parity_o (exp_parity)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_mode_q <= 1'b0;
      par_bit_q  <= 1'b0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
      par_bit_q  <= par_bit_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Count is cleared on every state change, so each terminal compare is relative to the last mid-bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    par_bit_d  = par_bit_q;
    done_d     = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          cnt_d      = '0;
          par_en_d   = PARITY_EN;
          par_mode_d = PARITY_MODE;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (RX_BR_TICKS) begin
          if (cnt_q == MID_CNT) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (RX_BR_TICKS) begin
          if (cnt_q == BIT_CNT) begin
            cnt_d   = '0;
            shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
            if (bit_q == LAST_BIT) begin
              state_d = par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (RX_BR_TICKS) begin
          if (cnt_q == BIT_CNT) begin
            cnt_d     = '0;
            par_bit_d = rx_s_q;
            state_d   = ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (RX_BR_TICKS) begin
          if (cnt_q == BIT_CNT) begin
            cnt_d   = '0;
            data_d  = shift_q;
            ferr_d  = ~rx_s_q;
            perr_d  = par_en_q & (exp_parity != par_bit_q);
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign RX_DATA_OUT = data_q;
  assign RX_DONE     = done_q;
  assign PARITY_ERR  = perr_q;
  assign FRAME_ERR   = ferr_q;
  assign State_dbg   = 3'(state_q);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int TICK_DIV = 4;
  localparam int BITC     = 16 * TICK_DIV;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } res_t;

  typedef struct {
    logic [7:0] d;
    logic       en;
    logic       mode;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       RX_BR_TICKS = 1'b0;
  logic       PARITY_EN = 1'b0;
  logic       PARITY_MODE = 1'b0;
  logic       RX = 1'b1;
  logic [7:0] RX_DATA_OUT;
  logic       RX_DONE;
  logic       PARITY_ERR;
  logic       FRAME_ERR;
  logic [2:0] State_dbg;

  int   tests = 0;
  int   fails = 0;
  int   hold_err = 0;
  int   tick_div = 0;
  res_t exp_q[$];
  res_t got_q[$];
  logic prev_done = 1'b0;
  logic [9:0] prev_out = '0;
  vec_t vecs[8];

  uart_receiver #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .RX_BR_TICKS (RX_BR_TICKS),
    .PARITY_EN   (PARITY_EN),
    .PARITY_MODE (PARITY_MODE),
    .RX          (RX),
    .RX_DATA_OUT (RX_DATA_OUT),
    .RX_DONE     (RX_DONE),
    .PARITY_ERR  (PARITY_ERR),
    .FRAME_ERR   (FRAME_ERR),
    .State_dbg   (State_dbg)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    tick_div = (tick_div + 1) % TICK_DIV;
    RX_BR_TICKS = (tick_div == 0);
  end

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (RX_DONE) begin
        tests++;
        if (prev_done) begin
          fails++;
          $display("FAIL done_width: RX_DONE high 2 cycles, required 1");
        end
        got_q.push_back({RX_DATA_OUT, PARITY_ERR, FRAME_ERR});
      end else if ({RX_DATA_OUT, PARITY_ERR, FRAME_ERR} !== prev_out) begin
        hold_err++;
      end
      prev_done = RX_DONE;
    end else begin
      prev_done = 1'b0;
    end
    prev_out = {RX_DATA_OUT, PARITY_ERR, FRAME_ERR};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic res_t model(input logic [7:0] d, input logic en, input logic mode,
                                 input logic pbit, input logic stop);
    res_t r;
    int   ones;
    ones = $countones(d);
    r.d  = d;
    r.fe = !stop;
    r.pe = en && (pbit != (logic'(ones % 2) ^ mode));
    return r;
  endfunction

  // A bad stop is held low for 3/4 bit so the receiver's re-arm sees only a short glitch.
  task automatic send_frame(input logic [7:0] d, input logic en, input logic mode,
                            input logic pbit, input logic stop);
    PARITY_EN = en;
    PARITY_MODE = mode;
    RX = 1'b0;
    wait_clks(BITC / 2);
    PARITY_EN = 1'($urandom);
    PARITY_MODE = 1'($urandom);
    wait_clks(BITC / 2);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      wait_clks(BITC);
    end
    if (en) begin
      RX = pbit;
      wait_clks(BITC);
    end
    if (stop) begin
      RX = 1'b1;
      wait_clks(BITC);
    end else begin
      RX = 1'b0;
      wait_clks(BITC * 3 / 4);
      RX = 1'b1;
      wait_clks(BITC / 4);
    end
  endtask

  task automatic drain(input string tag);
    int   t;
    res_t e;
    res_t g;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 4000) begin
      @(negedge CLK);
      t++;
    end
    wait_clks(8);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_data"}, 32'(g.d), 32'(e.d));
      chk({tag, "_perr"}, 32'(g.pe), 32'(e.pe));
      chk({tag, "_ferr"}, 32'(g.fe), 32'(e.fe));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] d;
    logic       en, mode, pbit, stop;
    res_t       r;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};

    wait_clks(5);
    chk("rst_data", 32'(RX_DATA_OUT), 0);
    chk("rst_done", 32'(RX_DONE), 0);
    chk("rst_perr", 32'(PARITY_ERR), 0);
    chk("rst_ferr", 32'(FRAME_ERR), 0);
    chk("rst_state", 32'(State_dbg), 0);
    RESET_N = 1'b1;
    wait_clks(BITC);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].d, vecs[i].en, vecs[i].mode, vecs[i].pbit, vecs[i].stop);
      exp_q.push_back({vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe});
      wait_clks(2 * BITC);
      drain($sformatf("vec%0d", i));
    end

    RX = 1'b0;
    wait_clks(10);
    chk("glitch_start", 32'(State_dbg), 1);
    wait_clks(10);
    RX = 1'b1;
    wait_clks(200);
    chk("glitch_idle", 32'(State_dbg), 0);
    chk("glitch_nodone", got_q.size(), 0);
    chk("glitch_data", 32'(RX_DATA_OUT), 32'hFF);
    chk("glitch_perr", 32'(PARITY_ERR), 1);

    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      en   = 1'($urandom);
      mode = 1'($urandom);
      pbit = 1'($countones(d) % 2) ^ mode ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, en, mode, pbit, stop);
      r = model(d, en, mode, pbit, stop);
      exp_q.push_back(r);
      if (!stop) wait_clks(2 * BITC);
      else if ($urandom_range(0, 1) == 1) wait_clks($urandom_range(0, BITC));
    end
    drain("rand");

    v = 8'hC3;
    PARITY_EN = 1'b0;
    RX = 1'b0;
    wait_clks(BITC);
    for (int i = 0; i < 3; i++) begin
      RX = v[i];
      wait_clks(BITC);
    end
    RX = v[3];
    wait_clks(BITC / 2);
    chk("mid_frame_state", 32'(State_dbg), 2);
    RESET_N = 1'b0;
    #1;
    chk("arst_data", 32'(RX_DATA_OUT), 0);
    chk("arst_done", 32'(RX_DONE), 0);
    chk("arst_perr", 32'(PARITY_ERR), 0);
    chk("arst_ferr", 32'(FRAME_ERR), 0);
    chk("arst_state", 32'(State_dbg), 0);
    wait_clks(3);
    RX = 1'b1;
    wait_clks(2);
    RESET_N = 1'b1;
    wait_clks(10 * BITC);
    chk("post_rst_nodone", got_q.size(), 0);
    chk("post_rst_state", 32'(State_dbg), 0);

    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({8'h55, 1'b0, 1'b0});
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({8'hF0, 1'b0, 1'b0});
    drain("b2b");

    chk("hold_outside_done", hold_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
